// File: rtl/sum_7r.sv
// 7-bit ripple-carry adder: Sout = Ain + Bin + Ci, carry-out on Co.
module sum_7r (
    input  logic [6:0] Ain,
    input  logic [6:0] Bin,
    input  logic       Ci,
    output logic [6:0] Sout,
    output logic       Co
);

    localparam int unsigned W = 7;

    logic carry;

    // Carry ripples LSB to MSB through one full adder per bit.
    always_comb begin
        carry = Ci;
        Sout  = '0;
        for (int i = 0; i < int'(W); i++) begin
            Sout[i] = Ain[i] ^ Bin[i] ^ carry;
            carry   = (Ain[i] & Bin[i]) | (carry & (Ain[i] ^ Bin[i]));
        end
        Co = carry;
    end

endmodule

// File: rtl/acc_7r.sv
// Counted 7-bit accumulator around sum_7r: start/len command, valid/ready operand
// stream in, valid/ready result out, sticky carry-out flag per run.
module acc_7r #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [6:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [6:0]       sum,
    output logic             ovf,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy
);

    localparam int unsigned DW = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DW-1:0]    acc;
    logic [DW-1:0]    acc_nxt;
    logic             ovf_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [DW-1:0]    add_s;
    logic             add_co;
    logic             beat;

    sum_7r u_add (
        .Ain  (acc),
        .Bin  (din),
        .Ci   (1'b0),
        .Sout (add_s),
        .Co   (add_co)
    );

    // din_ready is a registered state decode, so a beat never depends on din_valid combinationally.
    assign beat = din_valid & din_ready;
    assign sum  = acc;

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    acc_nxt = '0;
                    ovf_nxt = 1'b0;
                    if (len != '0) begin
                        cnt_nxt   = len;
                        state_nxt = S_ACC;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_ACC: begin
                if (beat) begin
                    acc_nxt = add_s;
                    ovf_nxt = ovf | add_co;
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (dout_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            ovf        <= 1'b0;
            cnt        <= '0;
            din_ready  <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            ovf        <= ovf_nxt;
            cnt        <= cnt_nxt;
            din_ready  <= (state_nxt == S_ACC);
            dout_valid <= (state_nxt == S_DONE);
            busy       <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_acc_7r.sv
// Directed bench for acc_7r with a per-cycle comparison against a run-level model.
module tb_acc_7r;

    localparam int unsigned CNT_W = 4;
    localparam int PH_IDLE = 0;
    localparam int PH_ACC  = 1;
    localparam int PH_DONE = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic [6:0]       din = '0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic [6:0]       sum;
    logic             ovf;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: unbounded running total per run; sum/ovf derived from it.
    int m_ph   = PH_IDLE;
    int m_raw  = 0;
    int m_left = 0;

    acc_7r #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sum        (sum),
        .ovf        (ovf),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            m_ph  = PH_IDLE;
            m_raw = 0;
            m_left = 0;
        end else begin
            case (m_ph)
                PH_IDLE: if (start) begin
                    m_raw = 0;
                    if (len == 0) m_ph = PH_DONE;
                    else begin
                        m_left = int'(len);
                        m_ph   = PH_ACC;
                    end
                end
                PH_ACC: if (din_valid) begin
                    m_raw  = m_raw + int'(din);
                    m_left = m_left - 1;
                    if (m_left == 0) m_ph = PH_DONE;
                end
                PH_DONE: if (dout_ready) m_ph = PH_IDLE;
                default: m_ph = PH_IDLE;
            endcase
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Every cycle after the first reset, all outputs must match the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("sum",        int'(sum),        m_raw % 128);
            chk("ovf",        int'(ovf),        int'(m_raw >= 128));
            chk("din_ready",  int'(din_ready),  int'(m_ph == PH_ACC));
            chk("dout_valid", int'(dout_valid), int'(m_ph == PH_DONE));
            chk("busy",       int'(busy),       int'(m_ph != PH_IDLE));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = CNT_W'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one operand, wait for its beat, then idle the stream for gap cycles.
    task automatic send(input int d, input int gap);
        int budget;
        din       = 7'(d);
        din_valid = 1'b1;
        budget    = 0;
        while (din_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (din_ready !== 1'b1) chk("beat_timeout", 0, 1);
        @(negedge clk);
        din_valid = 1'b0;
        cyc(gap);
    endtask

    task automatic accept();
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    initial begin
        // Reset, then idle.
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_sum", int'(sum), 0);
        chk("rst_busy", int'(busy), 0);
        cyc(5);

        // Basic run: 10+20+30.
        do_start(3);
        send(10, 0); send(20, 0); send(30, 0);
        chk("basic_lat", int'(dout_valid), 1);
        chk("basic_sum", int'(sum), 60);
        chk("basic_ovf", int'(ovf), 0);
        accept();
        chk("basic_idle_valid", int'(dout_valid), 0);
        chk("basic_hold_sum", int'(sum), 60);
        cyc(2);

        // Overflow: 100+50 = 150 -> 22.
        do_start(2);
        send(100, 0); send(50, 0);
        chk("ovf_sum", int'(sum), 22);
        chk("ovf_flag", int'(ovf), 1);
        accept();

        // Longest run: 15 x 127 = 1905 -> 113.
        do_start(15);
        for (int i = 0; i < 15; i++) send(127, 0);
        chk("long_sum", int'(sum), 113);
        chk("long_ovf", int'(ovf), 1);
        accept();

        // Gaps between beats and ignored start pulses: 70+40+20 = 130 -> 2.
        do_start(3);
        send(70, 2);
        start = 1'b1; len = 4'd7;
        @(negedge clk);
        start = 1'b0;
        send(40, 2);
        send(20, 0);
        chk("gap_sum", int'(sum), 2);
        chk("gap_ovf", int'(ovf), 1);
        for (int i = 0; i < 4; i++) begin
            start = (i == 1);
            len   = 4'd5;
            @(negedge clk);
            chk("done_hold_valid", int'(dout_valid), 1);
            chk("done_hold_sum", int'(sum), 2);
        end
        start = 1'b0;
        start = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; dout_ready = 1'b0;
        chk("start_in_done_busy", int'(busy), 0);
        cyc(2);

        // Empty run, with an operand offered that must not be consumed.
        din = 7'd9; din_valid = 1'b1;
        do_start(0);
        chk("empty_valid", int'(dout_valid), 1);
        chk("empty_ready", int'(din_ready), 0);
        chk("empty_sum", int'(sum), 0);
        cyc(2);
        din_valid = 1'b0;
        accept();
        cyc(1);

        // Reset mid-run after two of four beats.
        do_start(4);
        send(11, 0); send(12, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_sum", int'(sum), 0);
        chk("midrst_valid", int'(dout_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        cyc(1);
        do_start(1);
        send(5, 0);
        chk("after_rst_sum", int'(sum), 5);
        chk("after_rst_ovf", int'(ovf), 0);
        accept();
        cyc(3);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/acc_7r.md
Name: acc_7r

Overview:
Sequential 7-bit accumulator that sits directly downstream of the 7-bit ripple-carry adder `sum_7r`. It instantiates `sum_7r` and ties the adder inputs as follows: Ain = accumulator register, Bin = incoming operand, Ci = 0. It registers Sout back into the accumulator and folds Co into a sticky overflow flag. A start command sets an operand count; operands arrive over a valid/ready stream, and the final sum is presented on a valid/ready output.

Parameters:
- CNT_W, 4, width of the operand-count field `len` and of the internal down-counter. The data width is fixed at 7 to match `sum_7r`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle command pulse; sampled in IDLE only
- len  input  CNT_W  number of operands to accumulate; latched on an accepted start
- din  input  7  operand
- din_valid  input  1  operand valid
- din_ready  output  1  block accepts an operand this cycle
- sum  output  7  accumulated result, modulo 128
- ovf  output  1  sticky: any adder carry-out during the current run
- dout_valid  output  1  result valid
- dout_ready  input  1  consumer accepts the result
- busy  output  1  high in ACC and DONE

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, acc=0, ovf=0, cnt=0. Outputs: din_ready=0, dout_valid=0, busy=0, sum=0. Reset overrides every other input, including mid-run; no partial result is reported.
- `sum` is driven by acc at all times.
- State IDLE:
  - start=1, len!=0: acc<=0, ovf<=0, cnt<=len, go to ACC.
  - start=1, len==0: acc<=0, ovf<=0, go to DONE (empty sum).
  - start=0: hold state; acc and ovf keep the previous result.
- State ACC:
  - din_ready=1, decoded from state only (no combinational path from din_valid).
  - Beat = din_valid & din_ready. On a beat: acc<=Sout, ovf<=ovf|Co, cnt<=cnt-1. If cnt==1 on that beat, go to DONE.
  - No beat: acc, ovf and cnt hold. Gaps in din_valid of any length are legal.
- State DONE:
  - dout_valid=1, din_ready=0.
  - dout_ready=1: go to IDLE. dout_valid falls the next cycle; sum and ovf retain the result until the next accepted start.
  - dout_ready=0: hold indefinitely with sum and ovf stable.
- start is ignored in ACC and DONE, including when start and dout_ready are both 1 in DONE. It is only accepted from IDLE on a later cycle.
- Latency: dout_valid rises on the cycle after the last operand beat is accepted. Minimum run for N operands is N+1 cycles from the first beat to dout_valid.
- Arithmetic: acc(n+1) = (acc(n) + din) mod 128. ovf is set if any partial sum ≥ 128 and is never cleared within a run.
- The maximum operand count is 2^CNT_W−1. The counter never wraps, because runs with len=0 bypass ACC.

Test Plan:
- Reset then idle: rst held 2 cycles → sum=0, ovf=0, dout_valid=0, din_ready=0, busy=0. start=0 for 5 cycles → no change.
- Basic run: start, len=3; din=10, 20, 30 back-to-back → dout_valid on the cycle after the 3rd beat, sum=60, ovf=0. dout_ready=1 → IDLE next cycle, sum still 60.
- Overflow and long run:
  - len=2, din=100, 50 → sum=22, ovf=1.
  - len=15, din=127 each beat → sum=113, ovf=1.
- Backpressure:
  - len=3 with din_valid low for 2 cycles between beats → sum equals the gap-free result, cnt and acc held during gaps.
  - In DONE, dout_ready low for 4 cycles → dout_valid, sum and ovf stable. start pulses during ACC and DONE are ignored.
- Empty run: start, len=0 → DONE on the next cycle, sum=0, ovf=0, no din beats consumed (din_ready stays 0).
- Reset mid-run: len=4, 2 beats accepted, rst=1 → next cycle IDLE, sum=0, ovf=0, dout_valid=0. A subsequent run with len=1, din=5 → sum=5, ovf=0.
